sram_access_arbiter: RTL and testbench
======================================

# sram_access_arbiter

Shares the single 16-bit external SRAM between the audio recording path (writer) and the playback/DSP path (reader). It owns the SRAM pins, sequences multi-cycle read and write accesses, and keeps the record and play address pointers. It reports full and empty conditions so the top-level state machine can stop recording at memory end and stop playback at recording end. It sits between the I2S capture, the DSP fetch logic and the SRAM chip.

## Interface
- ADDR_W, 20: SRAM word-address width.
- DATA_W, 16: SRAM data width.
- ACC_CYC, 2: cycles per SRAM access, legal range 1..4.
- MAX_ADDR, 20'hFFFFF: last writable word address.

- i_clk  in  1: clock.
- i_rst  in  1: reset. One clock; reset is synchronous and active-high.
- wr_req  in  1: write request, level.
- wr_data  in  DATA_W: write sample, captured at grant.
- wr_ack  out  1: one-cycle pulse in the grant cycle; writer may change wr_data next cycle.
- wr_clr  in  1: pulse; wr_ptr <= 0 and rd_ptr <= 0 (new recording).
- rd_req  in  1: read request, level.
- rd_clr  in  1: pulse; rd_ptr <= 0 (replay from start).
- rd_data  out  DATA_W: read sample, valid with rd_valid.
- rd_valid  out  1: one-cycle pulse per completed read.
- full  out  1: wr_ptr > MAX_ADDR, meaning memory is exhausted.
- rd_empty  out  1: rd_ptr == wr_ptr, meaning there is no recorded data left.
- SRAM_ADDR  out  ADDR_W; SRAM_DQ  inout  DATA_W; SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  out  1: SRAM pins.

## Operation
- Pointers:
  - wr_ptr and rd_ptr are ADDR_W+1 bits wide.
  - A pointer increments by 1 in its grant cycle.
  - Pointers never wrap; wr_ptr saturates at MAX_ADDR+1.
- States: IDLE, WRITE, READ.
- IDLE arbitration, evaluated each cycle:
  - Write is eligible when wr_req && !full.
  - Read is eligible when rd_req && !rd_empty.
  - If neither is eligible, stay in IDLE.
  - If only one is eligible, grant it.
  - If both are eligible, the choice is set by the configuration macro (see Configuration).
- Write grant:
  - Capture wr_data and the address wr_ptr; wr_ack=1; wr_ptr++.
  - Go to WRITE.
- Read grant:
  - Capture the address rd_ptr; rd_ptr++.
  - Go to READ.
- WRITE:
  - Lasts ACC_CYC cycles.
  - SRAM_ADDR is the captured address, DQ is driven with the captured data, WE_N=0, OE_N=1.
  - Return to IDLE after the last cycle.
- READ:
  - Lasts ACC_CYC cycles.
  - DQ is high-Z, OE_N=0, WE_N=1.
  - DQ is sampled into rd_data at the last cycle's edge; rd_valid=1 in the following (IDLE) cycle.
- Static pins: CE_N, UB_N and LB_N are held at 0 out of reset.
- Held requests: a req held high streams back-to-back accesses, one per ACC_CYC+1 cycles.
- Clear pulses:
  - wr_clr or rd_clr has priority over a same-cycle pointer increment; the pointer ends at 0.
  - An in-flight access completes at its captured address.
  - wr_clr also clears rd_ptr.
- Empty/full handling:
  - A read request while rd_empty is not granted and produces no rd_valid.
  - A write request while full is not granted and produces no wr_ack.
- full and rd_empty are registered and are recomputed from the pointers every cycle.

## Timing
- Reset values:
  - state IDLE, wr_ptr=rd_ptr=0, SRAM_ADDR=0, DQ high-Z.
  - OE_N=1, WE_N=1, CE_N=UB_N=LB_N=0.
  - wr_ack=0, rd_valid=0, rd_data=0.
  - full=0, rd_empty=1, last-grant=read.
- Reset mid-access aborts at the next edge: WE_N/OE_N return to 1 and no ack or valid is issued afterwards.
- Write: req seen at cycle 0 gives wr_ack at cycle 0 (registered; req must be high at edge 0). WE_N is low in cycles 1..ACC_CYC.
- Read: grant at cycle 0, OE_N low in cycles 1..ACC_CYC, rd_valid at cycle ACC_CYC+1.
- Status flags: full and rd_empty update one cycle after the pointer change.
- All outputs are registered.

## Configuration
- SRAM_ARB_RR_EN defined:
  - Round-robin on contention: grant the side not granted last.
  - The last-grant register is updated on every grant.
- SRAM_ARB_RR_EN undefined:
  - Fixed write priority on contention, so the recorder never drops samples.
  - The last-grant register is not implemented.

## Test plan
- Reset, then wr_req held high for 4 samples (0x1111..0x4444) with ACC_CYC=2 -> wr_ack pulses every 3 cycles; SRAM writes to addresses 0..3; after the last write, wr_ptr=4 and rd_empty=0.
- rd_clr, then rd_req held high -> rd_valid returns 0x1111..0x4444 in order, each 3 cycles after its grant. After the 4th read rd_empty=1, and further rd_req is ignored with no rd_valid.
- wr_req and rd_req asserted together with data present -> without the macro, writes are always granted first; with SRAM_ARB_RR_EN, grants alternate W,R,W,R.
- MAX_ADDR=3: write 5 samples -> 4 wr_ack pulses; full=1 after the 4th; the 5th request gets no ack and SRAM_WE_N stays 1.
- i_rst asserted in the middle of a WRITE with ACC_CYC=4 -> WE_N=1 at the next edge, pointers are 0, and no ack or valid is produced afterwards.
- wr_clr in the same cycle as a write grant -> the access completes to the old address and wr_ptr=rd_ptr=0 afterwards.

Source files
------------

// File: rtl/sram_access_arbiter.sv
// rtl/sram_access_arbiter.sv - shares one external SRAM between the record (write) and playback (read) paths.
// Optional SRAM_ARB_RR_EN: round-robin on contention; default is fixed write priority.
module sram_access_arbiter #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16,
  parameter int ACC_CYC = 2,
  parameter logic [ADDR_W-1:0] MAX_ADDR = 20'hFFFFF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              wr_clr,
  input  logic              rd_req,
  input  logic              rd_clr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              rd_empty,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_t;

  localparam logic [2:0]      LP_LAST   = 3'(ACC_CYC - 1);
  localparam logic [ADDR_W:0] LP_WR_END = {1'b0, MAX_ADDR} + (ADDR_W+1)'(1);

  state_t            r_state;
  logic [2:0]        r_cnt;
  logic [ADDR_W:0]   r_wr_ptr;
  logic [ADDR_W:0]   r_rd_ptr;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_dq_out;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_dq_oe;
  logic              r_we_n;
  logic              r_oe_n;
  logic              r_wr_ack;
  logic              r_rd_valid;
  logic              r_full;
  logic              r_rd_empty;

  logic w_wr_elig;
  logic w_rd_elig;
  logic w_pick_wr;
  logic w_grant_wr;
  logic w_grant_rd;

  assign w_wr_elig = wr_req && !r_full;
  assign w_rd_elig = rd_req && !r_rd_empty;

`ifdef SRAM_ARB_RR_EN
  logic r_last_wr;
  assign w_pick_wr = w_wr_elig && (!w_rd_elig || !r_last_wr);
`else
  assign w_pick_wr = w_wr_elig;
`endif

  assign w_grant_wr = (r_state == S_IDLE) && w_pick_wr;
  assign w_grant_rd = (r_state == S_IDLE) && w_rd_elig && !w_pick_wr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_addr     <= '0;
      r_dq_out   <= '0;
      r_rd_data  <= '0;
      r_dq_oe    <= 1'b0;
      r_we_n     <= 1'b1;
      r_oe_n     <= 1'b1;
      r_wr_ack   <= 1'b0;
      r_rd_valid <= 1'b0;
      r_full     <= 1'b0;
      r_rd_empty <= 1'b1;
`ifdef SRAM_ARB_RR_EN
      r_last_wr  <= 1'b0;
`endif
    end else begin
      r_wr_ack   <= w_grant_wr;
      r_rd_valid <= 1'b0;
      // Strobes lag the state by one cycle so address/data settle in the grant cycle.
      r_we_n     <= (r_state != S_WRITE);
      r_oe_n     <= (r_state != S_READ);
      r_dq_oe    <= (r_state == S_WRITE);
      if (!r_oe_n && (r_state != S_READ)) begin
        r_rd_data  <= SRAM_DQ;
        r_rd_valid <= 1'b1;
      end
      r_full     <= (r_wr_ptr > {1'b0, MAX_ADDR});
      r_rd_empty <= (r_rd_ptr == r_wr_ptr);

      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_grant_wr) begin
            r_addr   <= r_wr_ptr[ADDR_W-1:0];
            r_dq_out <= wr_data;
            r_state  <= S_WRITE;
          end else if (w_grant_rd) begin
            r_addr  <= r_rd_ptr[ADDR_W-1:0];
            r_state <= S_READ;
          end
        end
        default: begin
          if (r_cnt == LP_LAST) r_state <= S_IDLE;
          else                  r_cnt   <= r_cnt + 3'd1;
        end
      endcase

      // Clears win over a same-cycle increment; the in-flight access keeps r_addr.
      if (wr_clr)
        r_wr_ptr <= '0;
      else if (w_grant_wr && (r_wr_ptr != LP_WR_END))
        r_wr_ptr <= r_wr_ptr + (ADDR_W+1)'(1);

      if (wr_clr || rd_clr)
        r_rd_ptr <= '0;
      else if (w_grant_rd)
        r_rd_ptr <= r_rd_ptr + (ADDR_W+1)'(1);

`ifdef SRAM_ARB_RR_EN
      if (w_grant_wr)      r_last_wr <= 1'b1;
      else if (w_grant_rd) r_last_wr <= 1'b0;
`endif
    end
  end

  assign SRAM_DQ   = r_dq_oe ? r_dq_out : 'z;
  assign SRAM_ADDR = r_addr;
  assign SRAM_WE_N = r_we_n;
  assign SRAM_OE_N = r_oe_n;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign wr_ack    = r_wr_ack;
  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;
  assign full      = r_full;
  assign rd_empty  = r_rd_empty;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// tb/tb_sram_access_arbiter.sv - bench for sram_access_arbiter: directed scenarios plus random traffic vs a transaction model.
`timescale 1ns/1ps
module tb_sram_access_arbiter;
  localparam int AW = 20, DW = 16, ACC = 2, MAXA = 7;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic wr_req = 1'b0, wr_clr = 1'b0, rd_req = 1'b0, rd_clr = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic wr_ack, rd_valid, full, rd_empty;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] SRAM_ADDR;
  wire  [DW-1:0] SRAM_DQ;
  logic SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;

  logic [DW-1:0] sram [0:7];
  logic [DW-1:0] samp [0:3] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

  sram_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACC_CYC(ACC), .MAX_ADDR(20'd7)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack), .wr_clr(wr_clr),
    .rd_req(rd_req), .rd_clr(rd_clr), .rd_data(rd_data), .rd_valid(rd_valid),
    .full(full), .rd_empty(rd_empty),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ(SRAM_DQ), .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N),
    .SRAM_WE_N(SRAM_WE_N), .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N)
  );

  always #5 i_clk = ~i_clk;

  assign SRAM_DQ = SRAM_OE_N ? 'z : sram[SRAM_ADDR[2:0]];
  always @(posedge i_clk) if (!SRAM_WE_N) sram[SRAM_ADDR[2:0]] <= SRAM_DQ;

  int n_total = 0, n_bad = 0, cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Transaction model: one access per ACC+1 cycles, pointers and memory as plain integers/arrays.
  int m_wp = 0, m_rp = 0, m_free = 0, m_wg = -100, m_rg = -100, m_rd_at = -1;
  bit m_last_wr = 1'b0;
  logic [DW-1:0] m_mem [0:7];
  logic [DW-1:0] m_rd_exp = '0;

  task automatic tick();
    bit we, re, pick_w, e_ack, e_val, e_full, e_empty;
    logic [DW-1:0] e_data;
    @(posedge i_clk);
    cyc++;
    e_ack = 0; e_val = 0; e_data = '0;
    e_full  = (m_wp > MAXA);
    e_empty = (m_rp == m_wp);
    if (i_rst) begin
      m_wp = 0; m_rp = 0; m_free = cyc + 1; m_wg = -100; m_rg = -100; m_rd_at = -1;
      m_last_wr = 0; e_full = 0; e_empty = 1;
    end else begin
      if (m_rd_at == cyc) begin e_val = 1; e_data = m_rd_exp; end
      if (cyc >= m_free) begin
        we = wr_req && (m_wp <= MAXA);
        re = rd_req && (m_rp != m_wp);
`ifdef SRAM_ARB_RR_EN
        pick_w = we && (!re || !m_last_wr);
`else
        pick_w = we;
`endif
        if (pick_w) begin
          e_ack = 1; m_mem[m_wp] = wr_data; m_wp++; m_wg = cyc; m_free = cyc + ACC + 1; m_last_wr = 1;
        end else if (re) begin
          m_rd_exp = m_mem[m_rp]; m_rd_at = cyc + ACC + 1; m_rp++; m_rg = cyc; m_free = cyc + ACC + 1;
          m_last_wr = 0;
        end
      end
      if (wr_clr) begin m_wp = 0; m_rp = 0; end
      if (rd_clr) m_rp = 0;
    end
    #1;
    check_eq("wr_ack", wr_ack, e_ack);
    check_eq("rd_valid", rd_valid, e_val);
    if (e_val) check_eq("rd_data", rd_data, e_data);
    check_eq("full", full, e_full);
    check_eq("rd_empty", rd_empty, e_empty);
    check_eq("we_n", SRAM_WE_N, !(cyc >= m_wg + 1 && cyc <= m_wg + ACC));
    check_eq("oe_n", SRAM_OE_N, !(cyc >= m_rg + 1 && cyc <= m_rg + ACC));
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic wr_burst(input int n);
    int last;
    bit got;
    last = -1;
    wr_req = 1;
    for (int k = 0; k < n; k++) begin
      got = 0;
      wr_data = samp[k % 4];
      for (int t = 0; t < 10 && !got; t++) begin
        tick();
        if (wr_ack) got = 1;
      end
      check_eq("ack_seen", got, 1);
      if (last >= 0) check_eq("ack_gap", cyc - last, ACC + 1);
      last = cyc;
    end
    wr_req = 0;
  endtask

  initial begin
    int cnt, ng;
    logic [15:0] order, exp_order;
    bit prev_oe, quiet;

    // Reset
    i_rst = 1; tick(); tick(); i_rst = 0;
    check_eq("rst_addr", SRAM_ADDR, 0);
    check_eq("rst_rd_data", rd_data, 0);
    check_eq("rst_static_n", {SRAM_CE_N, SRAM_UB_N, SRAM_LB_N}, 3'b000);
    tick();

    // Four held writes, then check SRAM contents
    wr_burst(4);
    run(3);
    for (int i = 0; i < 4; i++) check_eq("sram_wr", sram[i], samp[i]);
    check_eq("not_empty", rd_empty, 0);

    // Replay from start until empty; extra requests ignored
    rd_clr = 1; tick(); rd_clr = 0; tick();
    rd_req = 1; cnt = 0;
    for (int t = 0; t < 20; t++) begin tick(); if (rd_valid) cnt++; end
    rd_req = 0;
    check_eq("read_count", cnt, 4);

    // Contention: fill then drain with both requests held
    wr_clr = 1; tick(); wr_clr = 0; tick();
    wr_req = 1; rd_req = 1; order = '0; ng = 0; prev_oe = SRAM_OE_N;
    for (int t = 0; t < 70; t++) begin
      wr_data = DW'($urandom);
      tick();
      if (wr_ack && ng < 16) begin order[15-ng] = 1'b1; ng++; end
      if (prev_oe && !SRAM_OE_N && ng < 16) begin order[15-ng] = 1'b0; ng++; end
      prev_oe = SRAM_OE_N;
    end
`ifdef SRAM_ARB_RR_EN
    exp_order = 16'hAAAA;
`else
    exp_order = 16'hFF00;
`endif
    check_eq("grant_count", ng, 16);
    check_eq("grant_order", order, exp_order);
    check_eq("full_set", full, 1);
    check_eq("drained", rd_empty, 1);
    rd_req = 0; cnt = 0;
    for (int t = 0; t < 10; t++) begin tick(); if (wr_ack) cnt++; end
    wr_req = 0;
    check_eq("full_no_ack", cnt, 0);

    // Reset in the middle of a write
    wr_clr = 1; tick(); wr_clr = 0; tick();
    wr_data = 16'h5A5A; wr_req = 1; tick(); wr_req = 0;
    check_eq("mid_ack", wr_ack, 1);
    tick();
    check_eq("mid_we_low", SRAM_WE_N, 0);
    i_rst = 1; tick(); i_rst = 0;
    check_eq("rst_we_high", SRAM_WE_N, 1);
    cnt = 0;
    for (int t = 0; t < 8; t++) begin tick(); if (wr_ack || rd_valid) cnt++; end
    check_eq("post_rst_quiet", cnt, 0);

    // wr_clr coincident with a write grant
    wr_burst(3);
    run(3);
    wr_data = 16'hBEEF; wr_req = 1; wr_clr = 1; tick(); wr_req = 0; wr_clr = 0;
    check_eq("clr_ack", wr_ack, 1);
    run(4);
    check_eq("clr_old_addr", sram[3], 16'hBEEF);
    check_eq("clr_empty", rd_empty, 1);
    rd_req = 1; cnt = 0;
    for (int t = 0; t < 8; t++) begin tick(); if (rd_valid) cnt++; end
    rd_req = 0;
    check_eq("clr_no_read", cnt, 0);

    // Random traffic with occasional clears and resets
    quiet = 0;
    for (int i = 0; i < 2000; i++) begin
      int r;
      r = $urandom_range(0, 999);
      wr_clr = 0; rd_clr = 0; i_rst = 0;
      wr_data = DW'($urandom);
      if (quiet) begin
        wr_req = 0; rd_req = 0; quiet = 0;
      end else if (r < 4) begin
        i_rst = 1;
      end else if (r < 14) begin
        wr_req = 0; rd_req = 0; quiet = 1;
        if (r < 9) wr_clr = 1; else rd_clr = 1;
      end else begin
        wr_req = ($urandom_range(0, 99) < (((i / 150) % 2) == 1 ? 25 : 80));
        rd_req = ($urandom_range(0, 99) < 60);
      end
      tick();
    end
    wr_clr = 0; rd_clr = 0; i_rst = 0; wr_req = 0; rd_req = 0;
    run(5);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
